// File: rtl/if_prefetch_buffer.sv
// Fetch front end: pipelined imem requests gated by a credit count, responses queued as {pc, instr} for IF/ID.
// Push-to-valid takes one cycle; a MEM redirect empties the queue and drops every response still in flight.
module if_prefetch_buffer #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 redirect_i,
    input  logic [XLEN-1:0]                      redirect_pc_i,
    output logic                                 imem_req_o,
    output logic [XLEN-1:0]                      imem_addr_o,
    input  logic                                 imem_gnt_i,
    input  logic                                 imem_rvalid_i,
    input  logic [XLEN-1:0]                      imem_rdata_i,
    output logic                                 instr_valid_o,
    input  logic                                 instr_ready_i,
    output logic [XLEN-1:0]                      instr_o,
    output logic [XLEN-1:0]                      pc_o,
    output logic [XLEN-1:0]                      pc_four_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d;
    logic [PW-1:0]   pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
    logic [XLEN-1:0] pcq_q        [MAX_OUTSTANDING];
    logic [XLEN-1:0] pcq_d        [MAX_OUTSTANDING];
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [XLEN-1:0] fifo_pc_d    [DEPTH];
    logic [XLEN-1:0] fifo_instr_q [DEPTH];
    logic [XLEN-1:0] fifo_instr_d [DEPTH];
    logic [XLEN-1:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
    logic [31:0]     credit_used;
    logic            hs, rv, push, pop;
    logic            unused_redirect_lsbs;

    function automatic logic [PW-1:0] pcq_inc(input logic [PW-1:0] p);
        if (32'(p) == 32'(MAX_OUTSTANDING - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Credits cover buffered entries plus responses that will actually be kept.
    assign credit_used = 32'(count_q) + 32'(outstanding_q) - 32'(discard_q);
    assign imem_req_o  = !rst_i && !redirect_i
                         && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                         && (credit_used < 32'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign hs          = imem_req_o && imem_gnt_i;
    assign rv          = imem_rvalid_i && (outstanding_q != '0);
    assign push        = rv && (discard_q == '0) && !redirect_i;
    assign pop         = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o        = (count_q != '0);
    assign instr_o              = head_instr_q;
    assign pc_o                 = head_pc_q;
    assign pc_four_o            = head_pc_q + XLEN'(4);
    assign outstanding_o        = outstanding_q;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + OW'(hs) - OW'(rv);
        discard_d     = discard_q;
        pcq_rd_d      = pcq_rd_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_d         = pcq_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        head_pc_d     = head_pc_q;
        head_instr_d  = head_instr_q;

        if (hs) begin
            pcq_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d        = pcq_inc(pcq_wr_q);
            fetch_pc_d      = fetch_pc_q + XLEN'(4);
        end
        // Every response retires its PC slot, whether kept or dropped.
        if (rv) pcq_rd_d = pcq_inc(pcq_rd_q);

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = outstanding_q - OW'(rv);
        end else begin
            if (rv && discard_q != '0) discard_d = discard_q - OW'(1);
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = pcq_q[pcq_rd_q];
                fifo_instr_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d               = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // The next head comes straight from the response when the queue would otherwise be empty.
        if (count_d != '0) begin
            if (push && count_q == CW'(pop)) begin
                head_pc_d    = pcq_q[pcq_rd_q];
                head_instr_d = imem_rdata_i;
            end else begin
                head_pc_d    = fifo_pc_q[rd_ptr_d];
                head_instr_d = fifo_instr_q[rd_ptr_d];
            end
        end else if (count_q != '0) begin
            head_instr_d = NOP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
            head_pc_q     <= '0;
            head_instr_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pcq_rd_q      <= pcq_rd_d;
            pcq_wr_q      <= pcq_wr_d;
            head_pc_q     <= head_pc_d;
            head_instr_q  <= head_instr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pcq_q        <= pcq_d;
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

    rvalid_needs_request: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && outstanding_q == '0));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Scoreboard bench for if_prefetch_buffer: a latency-programmable imem model feeds an expected-output queue.
module tb_if_prefetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic        instr_valid_o, instr_ready_i;
    logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_four_o;
    logic [1:0]  outstanding_o;

    always #5 clk = ~clk;

    if_prefetch_buffer #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_four_o(pc_four_o), .outstanding_o(outstanding_o)
    );

    typedef struct { logic [31:0] addr; int due; bit drop; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    req_t        inflight[$];
    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, grants = 0, pops = 0, drops = 0;
    int          first_grant_cyc = -1, first_valid_cyc = -1;
    int          lat_min = 1, lat_max = 1;
    bit          gnt_rand = 0, rdy_rand = 0, rdy_val = 1;
    bit          rst_req = 1, redir_req = 0, resp_now = 0;
    logic [31:0] redir_tgt = 32'h0, exp_pc = 32'h0, last_gnt_addr = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endfunction

    // One clock: drive at negedge, score handshakes, then check registered state just after the edge.
    task automatic step();
        req_t r;
        exp_t e;
        int   exp_out;
        @(negedge clk);
        cyc++;
        if (!rst_req && rst_i) inflight.delete();
        rst_i         = rst_req;
        redirect_i    = redir_req;
        redirect_pc_i = redir_tgt;
        imem_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        instr_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        resp_now      = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rvalid_i = resp_now;
        imem_rdata_i  = resp_now ? instr_of(inflight[0].addr) : 32'h0;
        #1;
        if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rst_i || redirect_i) begin
            checks++;
            if (imem_req_o !== 1'b0) begin
                failures++; $display("FAIL req_masked: got %b required 0 (cycle %0d)", imem_req_o, cyc);
            end
        end
        if (instr_valid_o && instr_ready_i && !redirect_i && !rst_i) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL pop_unexpected: got pc=%h required no entry", pc_o);
            end else begin
                e = exp_q.pop_front();
                if (pc_o !== e.pc || instr_o !== e.instr || pc_four_o !== e.pc + 32'd4) begin
                    failures++;
                    $display("FAIL pop_data: got pc=%h instr=%h pc4=%h required pc=%h instr=%h pc4=%h",
                             pc_o, instr_o, pc_four_o, e.pc, e.instr, e.pc + 32'd4);
                end
            end
        end
        if (imem_req_o && imem_gnt_i) begin
            checks++;
            if (imem_addr_o !== exp_pc) begin
                failures++; $display("FAIL grant_addr: got %h required %h", imem_addr_o, exp_pc);
            end
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
            r.addr = exp_pc;
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            r.drop = 1'b0;
            inflight.push_back(r);
            last_gnt_addr = exp_pc;
            exp_pc += 32'd4;
            grants++;
        end
        if (resp_now) begin
            r = inflight.pop_front();
            if (r.drop || redirect_i || rst_i) drops++;
            else begin
                e.pc = r.addr; e.instr = instr_of(r.addr);
                exp_q.push_back(e);
            end
        end
        if (redirect_i) begin
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            exp_q.delete();
            exp_pc = {redir_tgt[31:2], 2'b00};
        end
        if (rst_i) begin
            exp_q.delete();
            exp_pc = 32'h0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid_o !== (exp_q.size() != 0)) begin
            failures++; $display("FAIL valid: got %b required %b", instr_valid_o, exp_q.size() != 0);
        end
        exp_out = rst_i ? 0 : inflight.size();
        checks++;
        if (outstanding_o !== 2'(exp_out)) begin
            failures++; $display("FAIL outstanding: got %0d required %0d", outstanding_o, exp_out);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (pc_o !== exp_q[0].pc || instr_o !== exp_q[0].instr) begin
                failures++;
                $display("FAIL head: got pc=%h instr=%h required pc=%h instr=%h",
                         pc_o, instr_o, exp_q[0].pc, exp_q[0].instr);
            end
        end
    endtask

    task automatic apply_reset();
        rst_req = 1; step(); step(); rst_req = 0;
    endtask

    task automatic test_reset();
        gnt_rand = 0; rdy_rand = 0; rdy_val = 1; lat_min = 1; lat_max = 1;
        rst_req = 1;
        step();
        checks++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || outstanding_o !== 2'd0) begin
            failures++; $display("FAIL reset_ctrl: got req=%b valid=%b out=%0d required 0 0 0",
                                 imem_req_o, instr_valid_o, outstanding_o);
        end
        checks++;
        if (instr_o !== 32'h0 || pc_o !== 32'h0 || pc_four_o !== 32'h4 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL reset_data: got instr=%h pc=%h pc4=%h addr=%h required 0 0 4 0",
                                 instr_o, pc_o, pc_four_o, imem_addr_o);
        end
        step();
    endtask

    task automatic test_stream();
        bit seen0 = 0, seen1 = 0;
        first_grant_cyc = -1; first_valid_cyc = -1;
        rdy_val = 1; lat_min = 1; lat_max = 1;
        rst_req = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (instr_valid_o && seen0 && !seen1) begin
                seen1 = 1; checks++;
                if (pc_o !== 32'h4 || pc_four_o !== 32'h8) begin
                    failures++; $display("FAIL stream_second: got %h/%h required 4/8", pc_o, pc_four_o);
                end
            end
            if (instr_valid_o && !seen0) begin
                seen0 = 1; checks++;
                if (pc_o !== 32'h0 || pc_four_o !== 32'h4) begin
                    failures++; $display("FAIL stream_first: got %h/%h required 0/4", pc_o, pc_four_o);
                end
            end
        end
        checks++;
        if (first_grant_cyc < 0 || first_valid_cyc - first_grant_cyc != 2) begin
            failures++; $display("FAIL stream_latency: got %0d required 2", first_valid_cyc - first_grant_cyc);
        end
    endtask

    task automatic test_backpressure();
        int  g0, p0;
        bit  got = 0;
        apply_reset();
        rdy_val = 0; lat_min = 1; lat_max = 1;
        g0 = grants;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (grants - g0 != 4) begin
            failures++; $display("FAIL bp_grants: got %0d required 4", grants - g0);
        end
        checks++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'h0 || instr_valid_o !== 1'b1) begin
            failures++; $display("FAIL bp_hold: got req=%b pc=%h valid=%b required 0 0 1",
                                 imem_req_o, pc_o, instr_valid_o);
        end
        rdy_val = 1; p0 = pops; g0 = grants;
        for (int i = 0; i < 4; i++) begin
            step();
            if (grants == g0 + 1 && !got) begin
                got = 1; checks++;
                if (last_gnt_addr !== 32'h10) begin
                    failures++; $display("FAIL bp_resume: got %h required 00000010", last_gnt_addr);
                end
            end
        end
        checks++;
        if (pops - p0 != 4 || !got) begin
            failures++; $display("FAIL bp_drain: got pops=%0d resumed=%b required 4 1", pops - p0, got);
        end
    endtask

    task automatic test_outstanding();
        int max_out = 0;
        apply_reset();
        rdy_val = 1; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            step();
            if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
            if (outstanding_o == 2'd2) begin
                checks++;
                if (imem_req_o !== 1'b0) begin
                    failures++; $display("FAIL out_cap_req: got %b required 0", imem_req_o);
                end
            end
        end
        checks++;
        if (max_out != 2) begin
            failures++; $display("FAIL out_max: got %0d required 2", max_out);
        end
    endtask

    task automatic test_redirect();
        int d0;
        apply_reset();
        rdy_val = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && !(exp_q.size() == 2 && inflight.size() == 2); i++) step();
        checks++;
        if (!(exp_q.size() == 2 && inflight.size() == 2)) begin
            failures++; $display("FAIL redir_setup: got buffered=%0d inflight=%0d required 2 2",
                                 exp_q.size(), inflight.size());
        end
        d0 = drops;
        redir_req = 1; redir_tgt = 32'h103;
        step();
        redir_req = 0;
        checks++;
        if (instr_valid_o !== 1'b0 || instr_o !== NOP || imem_addr_o !== 32'h100) begin
            failures++; $display("FAIL redir_flush: got valid=%b instr=%h addr=%h required 0 %h 00000100",
                                 instr_valid_o, instr_o, imem_addr_o, NOP);
        end
        rdy_val = 1;
        for (int i = 0; i < 20 && !instr_valid_o; i++) step();
        checks++;
        if (pc_o !== 32'h100 || instr_o !== instr_of(32'h100) || drops - d0 != 2) begin
            failures++; $display("FAIL redir_first: got pc=%h drops=%0d required 00000100 2", pc_o, drops - d0);
        end
    endtask

    task automatic test_redirect_collide();
        int d0, pre_out;
        bit hit;
        apply_reset();
        rdy_val = 1; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 30 && !(instr_valid_o && inflight.size() > 0 && inflight[0].due <= cyc + 1); i++)
            step();
        pre_out = inflight.size();
        d0 = drops;
        redir_req = 1; redir_tgt = 32'h200;
        step();
        redir_req = 0;
        hit = resp_now;
        checks++;
        if (!hit || instr_valid_o !== 1'b0 || int'(outstanding_o) != pre_out - 1) begin
            failures++; $display("FAIL collide: got rvalid=%b valid=%b out=%0d required 1 0 %0d",
                                 hit, instr_valid_o, outstanding_o, pre_out - 1);
        end
        for (int i = 0; i < 20 && !instr_valid_o; i++) step();
        checks++;
        if (pc_o !== 32'h200 || drops - d0 != pre_out) begin
            failures++; $display("FAIL collide_first: got pc=%h drops=%0d required 00000200 %0d",
                                 pc_o, drops - d0, pre_out);
        end
    endtask

    task automatic test_wrap();
        int g0;
        rdy_val = 1; lat_min = 1; lat_max = 1;
        redir_req = 1; redir_tgt = 32'hFFFF_FFFC;
        step();
        redir_req = 0;
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_target: got %h required fffffffc", imem_addr_o);
        end
        g0 = grants;
        for (int i = 0; i < 20 && grants == g0; i++) step();
        checks++;
        if (grants == g0 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL wrap_next: got %h required 00000000", imem_addr_o);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset_midflight();
        int d0;
        rdy_val = 1; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && inflight.size() != 2; i++) step();
        d0 = drops;
        rst_req = 1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (drops - d0 != 2 || outstanding_o !== 2'd0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL rst_mid: got strays=%0d out=%0d valid=%b addr=%h required 2 0 0 0",
                                 drops - d0, outstanding_o, instr_valid_o, imem_addr_o);
        end
        checks++;
        if (pc_o !== 32'h0 || instr_o !== 32'h0) begin
            failures++; $display("FAIL rst_mid_head: got pc=%h instr=%h required 0 0", pc_o, instr_o);
        end
        rst_req = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10 && !instr_valid_o; i++) step();
        checks++;
        if (pc_o !== 32'h0 || instr_o !== instr_of(32'h0)) begin
            failures++; $display("FAIL rst_mid_first: got pc=%h instr=%h required 0 %h", pc_o, instr_o, instr_of(32'h0));
        end
    endtask

    task automatic test_random();
        int g0;
        gnt_rand = 1; rdy_rand = 1; lat_min = 1; lat_max = 4;
        g0 = grants;
        for (int i = 0; i < 400; i++) begin
            redir_req = ($urandom_range(0, 24) == 0);
            redir_tgt = $urandom;
            step();
        end
        redir_req = 0;
        checks++;
        if (grants - g0 < 50) begin
            failures++; $display("FAIL random_progress: got %0d grants required at least 50", grants - g0);
        end
    endtask

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_outstanding();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
